// File: rtl/switch_control_pkg.sv
// -----------------------------------------------------------------------------
// switch_control_pkg
// Shared definitions for the router switch controller: default port count and
// flit width, router port indices, and the allocation FSM state encoding.
// Imported by switch_control and FixedPriorityArbiter.
// -----------------------------------------------------------------------------
package switch_control_pkg;

  localparam int NPORT_DEF      = 5;
  localparam int FLIT_WIDTH_DEF = 16;
  localparam int IDX_W          = 3;

  // Router port indices; also used as mux select codes
  localparam logic [IDX_W-1:0] EAST  = 3'd0;
  localparam logic [IDX_W-1:0] WEST  = 3'd1;
  localparam logic [IDX_W-1:0] NORTH = 3'd2;
  localparam logic [IDX_W-1:0] SOUTH = 3'd3;
  localparam logic [IDX_W-1:0] LOCAL = 3'd4;

  // Allocation sequence: arbitrate -> route -> allocate
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_ALLOC = 2'd2
  } state_t;

endpackage

// File: rtl/switch_control_arbiter.sv
// -----------------------------------------------------------------------------
// FixedPriorityArbiter
// Combinational fixed-priority arbiter: the lowest-numbered active request wins.
// Ports:
//   i_enable  - when 0 no selection is reported
//   i_req     - request vector, one bit per requester
//   o_valid   - 1 when a requester is selected
//   o_index   - index of the selected requester (0 when o_valid = 0)
// -----------------------------------------------------------------------------
module FixedPriorityArbiter
  import switch_control_pkg::*;
#(
  parameter int N = NPORT_DEF
) (
  input  logic             i_enable,
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index
);

  // Scan from the top down so the lowest active index is the last one written
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    if (i_enable) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_valid = 1'b1;
          o_index = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/switch_control.sv
// -----------------------------------------------------------------------------
// switch_control
// Crossbar allocation controller of a 2D-mesh router. Pending headers are
// arbitrated one at a time, XY-routed, and granted an output if it is free.
// Connections are torn down when the owning input's sender flag falls.
// Ports:
//   i_clk      - clock, rising edge
//   i_rst_n    - asynchronous active-low reset
//   i_h        - per-input header pending
//   i_data     - per-input head flit, port p at [p*FLIT_WIDTH +: FLIT_WIDTH]
//   i_sender   - per-input packet-still-flowing flag
//   o_ack_h    - one-cycle header accept pulse to the granted input
//   o_mux_in   - per output, 3-bit index of the connected input
//   o_mux_out  - per input, 3-bit index of the connected output
//   o_free     - per output, 1 = unallocated
// -----------------------------------------------------------------------------
module switch_control
  import switch_control_pkg::*;
#(
  parameter int         NPORT       = NPORT_DEF,
  parameter int         FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter logic [7:0] ROUTER_ADDR = 8'h00
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NPORT-1:0]            i_h,
  input  logic [NPORT*FLIT_WIDTH-1:0] i_data,
  input  logic [NPORT-1:0]            i_sender,
  output logic [NPORT-1:0]            o_ack_h,
  output logic [NPORT*IDX_W-1:0]      o_mux_in,
  output logic [NPORT*IDX_W-1:0]      o_mux_out,
  output logic [NPORT-1:0]            o_free
);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_sel;
  logic [IDX_W-1:0]       r_dest;
  logic [NPORT-1:0]       r_free;
  logic [NPORT*IDX_W-1:0] r_muxIn;
  logic [NPORT*IDX_W-1:0] r_muxOut;
  logic [NPORT-1:0]       r_connectedIn;
  logic [NPORT-1:0]       r_blockedMask;
  logic [NPORT-1:0]       r_senderPrev;

  logic [NPORT-1:0] w_release;
  logic [NPORT-1:0] w_releaseIn;
  logic             w_anyRelease;
  logic [NPORT-1:0] w_pending;
  logic [NPORT-1:0] w_req;
  logic             w_allMasked;
  logic             w_grantValid;
  logic [IDX_W-1:0] w_grantIdx;
  logic             w_destFree;
  logic             w_alloc;
  logic             w_block;
  logic [NPORT-1:0] w_ack;
  logic [NPORT-1:0] w_blockedNext;
  logic [7:0]       w_headAddr;

  // XY routing, X resolved first. A U-turn to any port but LOCAL is redirected
  // to LOCAL so a packet never bounces back out of the port it came in on.
  function automatic logic [IDX_W-1:0] xyRoute(input logic [7:0] target,
                                               input logic [7:0] own,
                                               input logic [IDX_W-1:0] inPort);
    logic [IDX_W-1:0] dir;
    if (target[7:4] > own[7:4])      dir = EAST;
    else if (target[7:4] < own[7:4]) dir = WEST;
    else if (target[3:0] > own[3:0]) dir = NORTH;
    else if (target[3:0] < own[3:0]) dir = SOUTH;
    else                             dir = LOCAL;
    if (dir == inPort) dir = LOCAL;
    return dir;
  endfunction

  // A busy output is released when the sender flag of its owning input falls
  always_comb begin
    w_release   = '0;
    w_releaseIn = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (!r_free[o] && r_senderPrev[r_muxIn[o*IDX_W +: IDX_W]] &&
          !i_sender[r_muxIn[o*IDX_W +: IDX_W]]) begin
        w_release[o] = 1'b1;
        w_releaseIn[r_muxIn[o*IDX_W +: IDX_W]] = 1'b1;
      end
    end
  end

  assign w_anyRelease = |w_release;

  // Requests already holding a connection or recently refused are not offered
  // to the arbiter; if that hides every pending header the mask is dropped.
  assign w_pending   = i_h & ~r_connectedIn;
  assign w_req       = w_pending & ~r_blockedMask;
  assign w_allMasked = (w_pending != '0) && (w_req == '0);

  FixedPriorityArbiter #(
    .N (NPORT)
  ) u_arbiter (
    .i_enable (r_state == S_IDLE),
    .i_req    (w_req),
    .o_valid  (w_grantValid),
    .o_index  (w_grantIdx)
  );

  assign w_headAddr = i_data[r_sel*FLIT_WIDTH +: 8];

  // An output being released this cycle is not handed out in the same cycle
  assign w_destFree = r_free[r_dest] && !w_release[r_dest];
  assign w_alloc    = (r_state == S_ALLOC) && w_destFree;
  assign w_block    = (r_state == S_ALLOC) && !w_destFree;

  // The accept pulse is tied to the allocation decision in the same cycle
  always_comb begin
    w_ack = '0;
    if (w_alloc) w_ack[r_sel] = 1'b1;
  end

  // Release wipes the whole mask since a refused input may now succeed
  always_comb begin
    w_blockedNext = r_blockedMask;
    if (w_allMasked) w_blockedNext = '0;
    if (w_block)     w_blockedNext[r_sel] = 1'b1;
    if (w_anyRelease) w_blockedNext = '0;
  end

  // Allocation sequencer: latch winner, latch its route, then try to allocate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_dest  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grantValid) begin
            r_sel   <= w_grantIdx;
            r_state <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          r_dest  <= xyRoute(w_headAddr, ROUTER_ADDR, r_sel);
          r_state <= S_ALLOC;
        end
        S_ALLOC: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Connection table: releases and a new allocation on another output can
  // land on the same edge without interfering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_free        <= '1;
      r_muxIn       <= '0;
      r_muxOut      <= '0;
      r_connectedIn <= '0;
      r_blockedMask <= '0;
      r_senderPrev  <= '0;
    end else begin
      r_senderPrev  <= i_sender;
      r_blockedMask <= w_blockedNext;
      for (int o = 0; o < NPORT; o++) begin
        if (w_release[o]) r_free[o] <= 1'b1;
      end
      for (int i = 0; i < NPORT; i++) begin
        if (w_releaseIn[i]) r_connectedIn[i] <= 1'b0;
      end
      if (w_alloc) begin
        r_free[r_dest]                     <= 1'b0;
        r_connectedIn[r_sel]               <= 1'b1;
        r_muxIn[r_dest*IDX_W +: IDX_W]     <= r_sel;
        r_muxOut[r_sel*IDX_W +: IDX_W]     <= r_dest;
      end
    end
  end

  assign o_ack_h   = w_ack;
  assign o_free    = r_free;
  assign o_mux_in  = r_muxIn;
  assign o_mux_out = r_muxOut;

endmodule

// File: tb/tb_switch_control.sv
// -----------------------------------------------------------------------------
// tb_switch_control
// Self-checking bench for switch_control with ROUTER_ADDR = 8'h11. Expected
// grants are queued when headers are driven and checked by a monitor when the
// accept pulse appears; a table of single-header routes plus hand-written
// contention, back-to-back and reset sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_switch_control;
  import switch_control_pkg::*;

  localparam int NP = 5;
  localparam int FW = 16;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   i_h;
  logic [NP*FW-1:0] i_data;
  logic [NP-1:0]   i_sender;
  logic [NP-1:0]   o_ack_h;
  logic [NP*3-1:0] o_mux_in;
  logic [NP*3-1:0] o_mux_out;
  logic [NP-1:0]   o_free;

  switch_control #(
    .NPORT       (NP),
    .FLIT_WIDTH  (FW),
    .ROUTER_ADDR (8'h11)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_h       (i_h),
    .i_data    (i_data),
    .i_sender  (i_sender),
    .o_ack_h   (o_ack_h),
    .o_mux_in  (o_mux_in),
    .o_mux_out (o_mux_out),
    .o_free    (o_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] port;
    logic [2:0] dest;
  } expect_t;

  typedef struct {
    logic [2:0] port;
    logic [7:0] target;
    logic [2:0] dest;
  } vec_t;

  expect_t sbQueue[$];
  int      ackTimes[$];
  int      nTests = 0;
  int      nFail  = 0;
  int      cycleCount = 0;
  logic    checkPending = 1'b0;
  logic [2:0] pendPort;
  logic [2:0] pendDest;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every accept pulse must match the oldest queued grant, and the
  // connection table must show that grant one edge later.
  always @(negedge clk) begin
    expect_t e;
    if (checkPending) begin
      checkPending = 1'b0;
      checkOutput("mux_in", 32'(o_mux_in[pendDest*3 +: 3]), 32'(pendPort));
      checkOutput("mux_out", 32'(o_mux_out[pendPort*3 +: 3]), 32'(pendDest));
      checkOutput("free_dest", 32'(o_free[pendDest]), 32'd0);
    end
    if (o_ack_h !== '0) begin
      ackTimes.push_back(cycleCount);
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_ack", 32'(o_ack_h), 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("ack_port", 32'(o_ack_h), 32'(5'b1 << e.port));
        pendPort = e.port;
        pendDest = e.dest;
        checkPending = 1'b1;
      end
    end
  end

  // Drive a header on one port and queue the grant it should receive
  task automatic applyStimulus(input logic [2:0] port, input logic [7:0] target,
                               input logic [2:0] dest, input logic expectGrant);
    expect_t e;
    i_data[port*FW +: FW] = {8'hA5, target};
    i_h[port]      = 1'b1;
    i_sender[port] = 1'b1;
    if (expectGrant) begin
      e.port = port;
      e.dest = dest;
      sbQueue.push_back(e);
    end
  endtask

  // Count cycles from the current one (cycle 1) until an accept pulse
  task automatic waitAck(input int maxCycles, output int cyc, output logic [NP-1:0] ack);
    cyc = 1;
    ack = '0;
    while (cyc <= maxCycles) begin
      if (o_ack_h !== '0) begin
        ack = o_ack_h;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int cyc;
    logic [NP-1:0] ack;

    vecs[0] = '{port: LOCAL, target: 8'h21, dest: EAST};
    vecs[1] = '{port: EAST,  target: 8'h11, dest: LOCAL};
    vecs[2] = '{port: EAST,  target: 8'h12, dest: NORTH};
    vecs[3] = '{port: EAST,  target: 8'h01, dest: WEST};
    vecs[4] = '{port: EAST,  target: 8'h21, dest: LOCAL};
    vecs[5] = '{port: NORTH, target: 8'h1F, dest: LOCAL};
    vecs[6] = '{port: SOUTH, target: 8'h00, dest: WEST};
    vecs[7] = '{port: WEST,  target: 8'hF0, dest: EAST};

    rst_n = 1'b0;
    i_h = '0;
    i_data = '0;
    i_sender = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_free", 32'(o_free), 32'h1F);
    checkOutput("reset_ack", 32'(o_ack_h), 32'h0);
    checkOutput("reset_mux_in", 32'(o_mux_in), 32'h0);
    checkOutput("reset_mux_out", 32'(o_mux_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single headers: route, 3-cycle latency, then release
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].port, vecs[v].target, vecs[v].dest, 1'b1);
      waitAck(10, cyc, ack);
      checkOutput($sformatf("latency_v%0d", v), 32'(cyc), 32'd3);
      i_h[vecs[v].port] = 1'b0;
      @(negedge clk);
      i_sender[vecs[v].port] = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("release_v%0d", v), 32'(o_free), 32'h1F);
      @(negedge clk);
    end

    // WEST and NORTH contend for SOUTH; NORTH waits for WEST's release
    applyStimulus(WEST,  8'h10, SOUTH, 1'b1);
    applyStimulus(NORTH, 8'h10, SOUTH, 1'b1);
    waitAck(10, cyc, ack);
    checkOutput("contend_first_ack", 32'(ack), 32'h02);
    checkOutput("contend_latency", 32'(cyc), 32'd3);
    i_h[WEST] = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("north_still_waiting", 32'(sbQueue.size()), 32'd1);
    checkOutput("south_busy", 32'(o_free), 32'h17);
    i_sender[WEST] = 1'b0;
    waitAck(20, cyc, ack);
    checkOutput("north_granted", 32'(ack), 32'h04);
    i_h[NORTH] = 1'b0;
    @(negedge clk);
    checkOutput("south_reused", 32'(o_free), 32'h17);
    i_sender[NORTH] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("contend_release", 32'(o_free), 32'h1F);

    // Five headers to five distinct outputs, served back to back
    ackTimes.delete();
    applyStimulus(EAST,  8'h01, WEST,  1'b1);
    applyStimulus(WEST,  8'h21, EAST,  1'b1);
    applyStimulus(NORTH, 8'h10, SOUTH, 1'b1);
    applyStimulus(SOUTH, 8'h12, NORTH, 1'b1);
    applyStimulus(LOCAL, 8'h11, LOCAL, 1'b1);
    for (int k = 0; k < 5; k++) begin
      waitAck(10, cyc, ack);
      if (k == 0) checkOutput("b2b_first_latency", 32'(cyc), 32'd3);
      if (ack == '0) begin
        checkOutput("b2b_ack_timeout", 32'(k), 32'd5);
        break;
      end
      i_h = i_h & ~ack;
      @(negedge clk);
    end
    checkOutput("b2b_all_busy", 32'(o_free), 32'h00);
    checkOutput("b2b_ack_count", 32'(ackTimes.size()), 32'd5);
    for (int i = 1; i < ackTimes.size(); i++)
      checkOutput($sformatf("b2b_spacing_%0d", i), 32'(ackTimes[i] - ackTimes[i-1]), 32'd3);
    i_sender = '0;
    @(negedge clk);
    checkOutput("b2b_all_released", 32'(o_free), 32'h1F);
    @(negedge clk);

    // Reset asserted while a header is in the route step
    applyStimulus(EAST, 8'h12, NORTH, 1'b1);
    waitAck(10, cyc, ack);
    i_h[EAST] = 1'b0;
    @(negedge clk);
    applyStimulus(LOCAL, 8'h21, EAST, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_free", 32'(o_free), 32'h1F);
    checkOutput("midreset_ack", 32'(o_ack_h), 32'h0);
    repeat (3) @(negedge clk);
    i_sender[EAST] = 1'b0;
    sbQueue.push_back('{port: LOCAL, dest: EAST});
    rst_n = 1'b1;
    waitAck(10, cyc, ack);
    checkOutput("restart_latency", 32'(cyc), 32'd3);
    i_h[LOCAL] = 1'b0;
    @(negedge clk);
    i_sender[LOCAL] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("restart_release", 32'(o_free), 32'h1F);
    checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
